step_sequencer: RTL and testbench

//  Consumer end of the game pace divider: takes its toggling divided-clock output and turns

---
 rtl/step_sequencer_if.sv | 28 ++
 rtl/step_sequencer.sv | 143 ++++++++++++++
 tb/tb_step_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/step_sequencer_if.sv
// Game-mode package and the req/done handshake bundle between the step sequencer
// (master) and the move/check logic (slave).
package snake_pkg;
   typedef enum logic [1:0] {
      MENU  = 2'd0,
      GAME  = 2'd1,
      PAUSE = 2'd2,
      OVER  = 2'd3
   } game_mode;
endpackage

interface step_sequencer_if;
   logic move_req;
   logic move_done;
   logic check_req;
   logic check_done;
   logic step_commit;

   modport master (
      output move_req, check_req, step_commit,
      input  move_done, check_done
   );

   modport slave (
      input  move_req, check_req, step_commit,
      output move_done, check_done
   );
endinterface

// File: rtl/step_sequencer.sv
// Turns each divider toggle into one game step: move handshake, check handshake, commit.
// Optional per-phase watchdog enabled by defining STEP_WATCHDOG_EN.
module step_sequencer
   import snake_pkg::*;
#(
   parameter int unsigned STEP_BITS  = 16,
   parameter int unsigned OVR_BITS   = 8,
   parameter int unsigned WDT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   input  game_mode             mode,
   input  logic                 tick_in,
   step_sequencer_if.master     bus,
   output logic [STEP_BITS-1:0] step_cnt,
   output logic [OVR_BITS-1:0]  overrun_cnt,
   output logic                 wdt_flag
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MOVE   = 2'd1,
      S_CHECK  = 2'd2,
      S_COMMIT = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_tick_q;
   logic                 r_pending;
   logic                 w_pending_nxt;
   logic                 w_ovr_inc;
   logic                 w_edge;
   logic                 w_game;
   logic                 w_wdt_hit;
   logic [STEP_BITS-1:0] r_step_cnt;
   logic [OVR_BITS-1:0]  r_ovr_cnt;

   assign w_edge = (tick_in != r_tick_q);
   assign w_game = (mode == GAME);

`ifdef STEP_WATCHDOG_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] r_wdt_cnt;
   logic             r_wdt_flag;
   logic             w_phase_enter;

   // Timeout fires on the last allowed cycle of a phase whose done is still absent.
   assign w_wdt_hit = ((r_state == S_MOVE  && !bus.move_done) ||
                       (r_state == S_CHECK && !bus.check_done)) &&
                      (r_wdt_cnt == WDT_W'(WDT_CYCLES - 1));
   assign w_phase_enter = (w_state_nxt == S_MOVE || w_state_nxt == S_CHECK) &&
                          (w_state_nxt != r_state);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wdt_cnt  <= '0;
         r_wdt_flag <= 1'b0;
      end else begin
         if (w_phase_enter)
            r_wdt_cnt <= '0;
         else if (r_state == S_MOVE || r_state == S_CHECK)
            r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
         if (w_game && w_wdt_hit)
            r_wdt_flag <= 1'b1;
      end
   end

   assign wdt_flag = r_wdt_flag;
`else
   assign w_wdt_hit = 1'b0;
   assign wdt_flag  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_tick_q   <= 1'b0;
         r_pending  <= 1'b0;
         r_step_cnt <= '0;
         r_ovr_cnt  <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_tick_q  <= tick_in;
         r_pending <= w_pending_nxt;
         if (r_state == S_COMMIT)
            r_step_cnt <= r_step_cnt + STEP_BITS'(1);
         if (w_ovr_inc && (r_ovr_cnt != '1))
            r_ovr_cnt <= r_ovr_cnt + OVR_BITS'(1);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_ovr_inc     = 1'b0;
      if (!w_game) begin
         w_state_nxt   = S_IDLE;
         w_pending_nxt = 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_edge)
                  w_state_nxt = S_MOVE;
            end
            S_MOVE, S_CHECK: begin
               // One toggle is queued; any further ones during the step are lost.
               if (w_edge) begin
                  if (r_pending)
                     w_ovr_inc = 1'b1;
                  else
                     w_pending_nxt = 1'b1;
               end
               if (r_state == S_MOVE && bus.move_done)
                  w_state_nxt = S_CHECK;
               else if (r_state == S_CHECK && bus.check_done)
                  w_state_nxt = S_COMMIT;
               else if (w_wdt_hit) begin
                  w_state_nxt   = S_IDLE;
                  w_pending_nxt = 1'b0;
               end
            end
            S_COMMIT: begin
               if (r_pending || w_edge) begin
                  w_state_nxt   = S_MOVE;
                  w_pending_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign bus.move_req    = (r_state == S_MOVE);
   assign bus.check_req   = (r_state == S_CHECK);
   assign bus.step_commit = (r_state == S_COMMIT);
   assign step_cnt        = r_step_cnt;
   assign overrun_cnt     = r_ovr_cnt;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: a step-level reference model compared every cycle,
// plus hand-computed spot checks. Define STEP_WATCHDOG_EN to exercise the watchdog.
module tb_step_sequencer;
   import snake_pkg::*;

`ifdef STEP_WATCHDOG_EN
   localparam int TB_WDT = 8;
`else
   localparam int TB_WDT = 1024;
`endif

   logic        clk;
   logic        rst;
   game_mode    mode;
   logic        tick_in;
   logic        tick_w;
   logic [15:0] step_cnt;
   logic [7:0]  overrun_cnt;
   logic        wdt_flag;
   logic [3:0]  w_step_cnt;
   logic [2:0]  w_overrun_cnt;
   logic        w_wdt_flag;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 1'b0;

   step_sequencer_if sif ();
   step_sequencer_if ifw ();

   step_sequencer #(
      .STEP_BITS (16),
      .OVR_BITS  (8),
      .WDT_CYCLES(TB_WDT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .tick_in    (tick_in),
      .bus        (sif),
      .step_cnt   (step_cnt),
      .overrun_cnt(overrun_cnt),
      .wdt_flag   (wdt_flag)
   );

   // Narrow-counter instance with an instant responder, used to reach the wrap point.
   step_sequencer #(
      .STEP_BITS (4),
      .OVR_BITS  (3),
      .WDT_CYCLES(1024)
   ) dut_w (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .tick_in    (tick_w),
      .bus        (ifw),
      .step_cnt   (w_step_cnt),
      .overrun_cnt(w_overrun_cnt),
      .wdt_flag   (w_wdt_flag)
   );

   assign ifw.move_done  = ifw.move_req;
   assign ifw.check_done = ifw.check_req;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: want = which ack the current step awaits (0 none, 1 move, 2 check, 3 done).
   int          m_want   = 0;
   int          m_queued = 0;
   int          m_ovr    = 0;
   int          m_timer  = 0;
   int unsigned m_steps  = 0;
   bit          m_last   = 1'b0;
   bit          m_wflag  = 1'b0;

   always @(posedge clk) begin : model
      bit tg;
      bit ackd;
      tg     = (tick_in != m_last);
      m_last = tick_in;
      if (rst) begin
         m_want = 0; m_queued = 0; m_ovr = 0; m_timer = 0;
         m_steps = 0; m_last = 1'b0; m_wflag = 1'b0;
      end else begin
         if (m_want == 3) m_steps = (m_steps + 1) % 65536;
         if (mode != GAME) begin
            m_want = 0; m_queued = 0;
         end else if (m_want == 0) begin
            if (tg) begin m_want = 1; m_timer = 0; end
         end else if (m_want == 3) begin
            if (m_queued != 0 || tg) begin m_want = 1; m_queued = 0; m_timer = 0; end
            else m_want = 0;
         end else begin
            if (tg) begin
               if (m_queued != 0) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
               else m_queued = 1;
            end
            ackd = (m_want == 1) ? sif.move_done : sif.check_done;
            if (ackd) begin
               m_want = m_want + 1; m_timer = 0;
            end else begin
`ifdef STEP_WATCHDOG_EN
               m_timer = m_timer + 1;
               if (m_timer == TB_WDT) begin m_want = 0; m_queued = 0; m_wflag = 1'b1; end
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         n_checks++;
         if (sif.move_req !== (m_want == 1) || sif.check_req !== (m_want == 2) ||
             sif.step_commit !== (m_want == 3) || step_cnt !== m_steps[15:0] ||
             overrun_cnt !== 8'(m_ovr) || wdt_flag !== m_wflag) begin
            n_errors++;
            $display("FAIL cycle_cmp t=%0t got mr=%b cr=%b sc=%b cnt=%0d ovr=%0d wdt=%b required mr=%b cr=%b sc=%b cnt=%0d ovr=%0d wdt=%b",
                     $time, sif.move_req, sif.check_req, sif.step_commit, step_cnt, overrun_cnt,
                     wdt_flag, (m_want == 1), (m_want == 2), (m_want == 3), m_steps[15:0], m_ovr, m_wflag);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d required %0d at t=%0t", nm, got, exp, $time);
      end
   endtask

   task automatic toggle();
      tick_in = ~tick_in;
   endtask

   task automatic wait_req(input bit which);
      int k;
      k = 0;
      while (((which ? sif.check_req : sif.move_req) !== 1'b1) && k < 64) begin
         @(negedge clk);
         k++;
      end
      n_checks++;
      if (k >= 64) begin
         n_errors++;
         $display("FAIL wait_req%0d got timeout required req within 64 cycles", which);
      end
   endtask

   task automatic ack(input bit which, input int dly);
      wait_req(which);
      cyc(dly);
      if (which) sif.check_done = 1'b1;
      else       sif.move_done  = 1'b1;
      cyc(1);
      sif.move_done  = 1'b0;
      sif.check_done = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout got no finish required finish");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int n;
      rst = 1'b1; mode = MENU; tick_in = 1'b0; tick_w = 1'b0;
      sif.move_done = 1'b0; sif.check_done = 1'b0;
      cyc(3);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_move_req", 32'(sif.move_req), 0);
      chk("rst_step_cnt", 32'(step_cnt), 0);
      chk("rst_overrun", 32'(overrun_cnt), 0);

      // 1: single step, each done one cycle after its req
      mode = GAME; cyc(1);
      toggle(); cyc(1);
      chk("t1_move_req", 32'(sif.move_req), 1);
      ack(1'b0, 1);
      chk("t1_check_req", 32'(sif.check_req), 1);
      chk("t1_move_req_off", 32'(sif.move_req), 0);
      ack(1'b1, 1);
      chk("t1_commit", 32'(sif.step_commit), 1);
      cyc(1);
      chk("t1_commit_off", 32'(sif.step_commit), 0);
      chk("t1_step_cnt", 32'(step_cnt), 1);

      // 2: extra toggles during a stalled move
      toggle(); cyc(1);
      repeat (3) begin toggle(); cyc(1); end
      chk("t2_overrun", 32'(overrun_cnt), 2);
      ack(1'b0, 0); ack(1'b1, 0);
      cyc(1);
      chk("t2_step_cnt", 32'(step_cnt), 2);
      chk("t2_restart", 32'(sif.move_req), 1);
      ack(1'b0, 0); ack(1'b1, 0);
      cyc(1);
      chk("t2_step_cnt_b", 32'(step_cnt), 3);

      // minimum latency with immediate acks
      toggle();
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         sif.move_done  = sif.move_req;
         sif.check_done = sif.check_req;
         if (sif.step_commit === 1'b1) begin lat = k; break; end
      end
      sif.move_done = 1'b0; sif.check_done = 1'b0;
      chk("latency", 32'(lat), 3);
      cyc(1);

      // 4: leave GAME during CHECK
      toggle();
      ack(1'b0, 0);
      mode = MENU; cyc(1);
      chk("t4_check_off", 32'(sif.check_req), 0);
      chk("t4_no_commit", 32'(sif.step_commit), 0);
      repeat (3) begin toggle(); cyc(2); end
      chk("t4_ignored", 32'(sif.move_req), 0);
      chk("t4_step_hold", 32'(step_cnt), 4);
      mode = GAME; cyc(4);
      chk("t4_no_reentry_step", 32'(sif.move_req), 0);
      toggle(); cyc(1);
      chk("t4_resume", 32'(sif.move_req), 1);
      ack(1'b0, 0); ack(1'b1, 0); cyc(1);
      chk("t4_step_cnt", 32'(step_cnt), 5);

      // 5: wrap on the 4-bit instance
      repeat (17) begin tick_w = ~tick_w; cyc(4); end
      cyc(4);
      chk("t5_wrap", 32'(w_step_cnt), 1);
      chk("t5_no_overrun", 32'(w_overrun_cnt), 0);

      // reset mid-handshake
      toggle(); cyc(1);
      chk("rst_mid_pre", 32'(sif.move_req), 1);
      rst = 1'b1; tick_in = 1'b0; cyc(1);
      rst = 1'b0;
      chk("rst_mid_req", 32'(sif.move_req), 0);
      chk("rst_mid_cnt", 32'(step_cnt), 0);
      chk("rst_mid_ovr", 32'(overrun_cnt), 0);
      toggle();
      ack(1'b0, 0); ack(1'b1, 0); cyc(1);
      chk("rst_mid_step", 32'(step_cnt), 1);

`ifdef STEP_WATCHDOG_EN
      // 6: move_done never arrives
      toggle();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1);
         if (sif.move_req === 1'b1) n++;
      end
      chk("t6_move_cycles", 32'(n), 8);
      chk("t6_wdt_flag", 32'(wdt_flag), 1);
      toggle(); cyc(1);
      chk("t6_fresh_step", 32'(sif.move_req), 1);
      ack(1'b0, 0); ack(1'b1, 0); cyc(1);
      chk("t6_step_cnt", 32'(step_cnt), 2);
      chk("t6_wdt_sticky", 32'(wdt_flag), 1);
      rst = 1'b1; tick_in = 1'b0; cyc(1);
      rst = 1'b0;
      chk("t6_wdt_cleared", 32'(wdt_flag), 0);
`else
      // 3: saturate overruns
      toggle(); cyc(1);
      repeat (261) begin toggle(); cyc(1); end
      chk("t3_overrun_sat", 32'(overrun_cnt), 255);
      ack(1'b0, 0); ack(1'b1, 0);
      chk("t3_commit", 32'(sif.step_commit), 1);
      cyc(1);
      chk("t3_restart", 32'(sif.move_req), 1);
      ack(1'b0, 0); ack(1'b1, 0); cyc(1);
      chk("t3_step_cnt", 32'(step_cnt), 3);
      chk("t3_overrun_hold", 32'(overrun_cnt), 255);

      // no watchdog: a stalled move waits indefinitely
      toggle(); cyc(40);
      chk("hang_move_req", 32'(sif.move_req), 1);
      chk("hang_wdt", 32'(wdt_flag), 0);
      ack(1'b0, 0); ack(1'b1, 0); cyc(1);
      chk("hang_step_cnt", 32'(step_cnt), 4);
`endif

      cyc(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
